safe_domain_reg_if_req: RTL
===========================

# safe_domain_reg_if_req

Requester side of the four-phase register-interface handshake into the safe domain. It accepts single register commands from the SoC-side bus, holds address, data and direction stable, and drives `reg_if_req_o` across the domain boundary. It synchronises the returning `reg_if_ack_i`, completes the full req/ack return-to-zero cycle, and reports read data or a timeout error. It sits directly upstream of the safe-domain acknowledge logic, which edge-detects `reg_if_req_o` into rise/fall events.

## Interface
- `ADDR_W`, 8: register address width.
- `DATA_W`, 32: register data width.
- `SYNC_STAGES`, 2: flop count of the ack synchroniser; minimum 2.
- `TIMEOUT`, 255: maximum number of cycles `reg_if_req_o` stays high waiting for ack; minimum 2.

Ports:
- `clk_i`  in  1  requester-domain clock.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted this cycle when high with valid.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  ADDR_W  register address.
- `cmd_wdata_i`  in  DATA_W  write data.
- `rsp_valid_o`  out  1  one-cycle completion pulse.
- `rsp_rdata_o`  out  DATA_W  read data; valid with `rsp_valid_o`.
- `rsp_err_o`  out  1  timeout flag; valid with `rsp_valid_o`.
- `busy_o`  out  1  high whenever state is not IDLE.
- `reg_if_req_o`  out  1  handshake request to the safe domain.
- `reg_if_we_o`  out  1  latched direction.
- `reg_if_addr_o`  out  ADDR_W  latched address.
- `reg_if_wdata_o`  out  DATA_W  latched write data.
- `reg_if_rdata_i`  in  DATA_W  responder read data; stable while ack is high.
- `reg_if_ack_i`  in  1  asynchronous acknowledge from the safe domain.

## Operation
- **`ack_s`:** `reg_if_ack_i` passed through SYNC_STAGES flops (reset 0). Only `ack_s` is used internally.
- **State machine:** IDLE, REQ, RELEASE, RSP.
- **IDLE:**
  - `cmd_ready_o` = 1.
  - On valid & ready: latch we/addr/wdata into the `reg_if_*` outputs, clear `err_q` and the counter, go to REQ.
- **REQ:**
  - `reg_if_req_o` = 1. The counter increments each cycle while `ack_s` is 0.
  - If `ack_s` = 1: capture `reg_if_rdata_i` into `rdata_q` (capture 0 for writes), go to RELEASE.
  - Else if counter = TIMEOUT-1: set `err_q`, set `rdata_q` to 0, go to RELEASE.
  - If `ack_s` is seen on the timeout cycle, ack wins and no error is raised.
- **RELEASE:**
  - `reg_if_req_o` = 0. Stay here until `ack_s` = 0, then go to RSP.
  - There is no timeout. A stuck-high ack blocks the block indefinitely with `busy_o` = 1, and the block never re-asserts req into a pending ack.
- **RSP:**
  - `rsp_valid_o` = 1 for exactly one cycle, with `rsp_rdata_o` = `rdata_q` and `rsp_err_o` = `err_q`. Go to IDLE.
- **Output ownership:** `reg_if_req_o` is a registered state decode; it never glitches. `reg_if_we_o`, `reg_if_addr_o` and `reg_if_wdata_o` change only on acceptance in IDLE.
- **Data outside RSP:** `rsp_rdata_o` is 0 whenever `rsp_valid_o` is 0.
- **Illegal state encodings:** recover to IDLE.
- **Commands while busy:** `cmd_valid_i` outside IDLE is ignored; `cmd_ready_o` = 0.

## Timing
- **Reset values:** all outputs 0, except `cmd_ready_o` = 1 (IDLE). State = IDLE, synchroniser flops = 0.
- **Reset mid-operation:** `reg_if_req_o` drops asynchronously and any pending response is discarded (no `rsp_valid_o`).
- **Acceptance to request:** acceptance at edge N; `reg_if_req_o` is high from edge N+1.
- **Ack to release:** `reg_if_ack_i` rising before edge M gives `ack_s` high after edge M+SYNC_STAGES-1, and req falls one edge later.
- **Release to response:** ack falling follows the same synchroniser delay into RELEASE. `rsp_valid_o` is asserted the cycle after `ack_s` is seen low.
- **Timeout:** with no ack, `reg_if_req_o` is high for exactly TIMEOUT cycles.
- **Back-to-back:** a new command can be accepted in the cycle after `rsp_valid_o`.

## Structure
- **Package `safe_domain_pkg`:**
  - state enum `req_state_e`;
  - defaults for `ADDR_W`, `DATA_W`, `SYNC_STAGES`;
  - counter width `$clog2(TIMEOUT+1)`, shared with the acknowledge side.
- **Sub-module `safe_domain_sync`:** parameterised N-flop synchroniser with asynchronous active-low reset to 0. It is reused for the req synchroniser in the safe domain.

## Test plan
- **Write:** write addr 0x10, data 0xDEADBEEF; responder acks 3 cycles after req and drops ack 2 cycles after req falls. Required: addr/wdata/we stable throughout; one `rsp_valid_o` with err=0 and rdata=0.
- **Read:** read addr 0x04, responder rdata 0xCAFE0001. Required: `rsp_rdata_o` = 0xCAFE0001, err=0, rdata=0 on all other cycles.
- **Timeout:** TIMEOUT=8, no ack. Required: req high exactly 8 cycles, then `rsp_valid_o` with err=1 and rdata=0; `cmd_ready_o` returns 1 next cycle.
- **Stuck ack:** ack held high after handshake. Required: req stays 0, `busy_o` stays 1, no response and no new acceptance; releasing ack yields the response SYNC_STAGES+1 cycles later.
- **Reset mid-operation:** assert `rstn_i` low while in REQ. Required: req 0 immediately, no `rsp_valid_o`, `cmd_ready_o` = 1 after reset release.
- **Back-to-back:** two reads with `cmd_valid_i` held high. Required: second accepted the cycle after the first `rsp_valid_o`; each read returns its own rdata.

Source files
------------

// File: rtl/safe_domain_pkg.sv
// Shared types and defaults for the safe-domain register-interface handshake.
// Used by both the requester and the acknowledge side of the boundary.
package safe_domain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RSP     = 2'd3
  } req_state_e;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 255;

  // Timeout counter width; both sides must agree on it.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/safe_domain_sync.sv
// N-flop single-bit synchroniser, asynchronous active-low reset to 0.
// Shared by the ack path here and the req path in the safe domain.
module safe_domain_sync
  import safe_domain_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/safe_domain_reg_if_req.sv
// Requester side of the four-phase req/ack register handshake into the safe
// domain: one command in flight, full return-to-zero, read data or timeout.
module safe_domain_reg_if_req
  import safe_domain_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic              reg_if_req_o,
  output logic              reg_if_we_o,
  output logic [ADDR_W-1:0] reg_if_addr_o,
  output logic [DATA_W-1:0] reg_if_wdata_o,
  input  logic [DATA_W-1:0] reg_if_rdata_i,
  input  logic              reg_if_ack_i
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_REQ     = ST_REQ;
  localparam logic [1:0] S_RELEASE = ST_RELEASE;
  localparam logic [1:0] S_RSP     = ST_RSP;

  logic [1:0]        state_q, state_d;
  logic              req_q;
  logic              ack_s;
  logic              accept;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  safe_domain_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d      (reg_if_ack_i),
    .q      (ack_s)
  );

  assign accept = cmd_valid_i && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cmd_valid_i) state_d = S_REQ;
      S_REQ:     if (ack_s || (cnt_q == CNT_LAST)) state_d = S_RELEASE;
      S_RELEASE: if (!ack_s) state_d = S_RSP;
      S_RSP:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // req is decoded from the next state so it leaves a flop and never glitches.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == S_REQ);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      we_q    <= cmd_we_i;
      addr_q  <= cmd_addr_i;
      wdata_q <= cmd_wdata_i;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else if (state_q == S_REQ) begin
      // An ack arriving on the final count wins over the timeout.
      if (ack_s) begin
        rdata_q <= we_q ? '0 : reg_if_rdata_i;
      end else if (cnt_q == CNT_LAST) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else begin
        cnt_q   <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign cmd_ready_o    = (state_q == S_IDLE);
  assign busy_o         = (state_q != S_IDLE);
  assign rsp_valid_o    = (state_q == S_RSP);
  assign rsp_rdata_o    = rsp_valid_o ? rdata_q : '0;
  assign rsp_err_o      = rsp_valid_o && err_q;
  assign reg_if_req_o   = req_q;
  assign reg_if_we_o    = we_q;
  assign reg_if_addr_o  = addr_q;
  assign reg_if_wdata_o = wdata_q;

endmodule
